// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared encodings for the PC / memory-interface unit.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] PC_INC  = 2'd0;
    localparam logic [1:0] PC_REL  = 2'd1;
    localparam logic [1:0] PC_ABS  = 2'd2;
    localparam logic [1:0] PC_HOLD = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2,
        HALTED  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_mem_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_mem_unit_if
// Brief   : Shared memory port: command/address out, ready/read data back.
// Revision: 1.0 - initial release
// ============================================================================
interface pc_mem_unit_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] read_data;

    modport master (output mem_cmd, output mem_addr, input mem_ready, input read_data);
    modport slave  (input mem_cmd, input mem_addr, output mem_ready, output read_data);
endinterface
`default_nettype wire

// File: rtl/pc_mem_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_mem_unit
// Brief   : PC, data-address and instruction registers with fetch/data
//           arbitration of one memory port and a wait-state timeout.
// Revision: 1.0 - initial release
// ============================================================================
module pc_mem_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start_fetch,
    input  wire logic              mem_req,
    input  wire logic              mem_wr,
    input  wire logic              pc_load,
    input  wire logic [1:0]        pc_sel,
    input  wire logic [DATA_W-1:0] offset,
    input  wire logic [DATA_W-1:0] abs_addr,
    input  wire logic              load_addr,
    input  wire logic              halt,
    pc_mem_unit_if.master          mem,
    output logic      [DATA_W-1:0] ir,
    output logic      [ADDR_W-1:0] pc,
    output logic                   ir_valid,
    output logic                   data_done,
    output logic                   busy,
    output logic                   halted,
    output logic                   err
);

    localparam int                WAIT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_da;
    logic [DATA_W-1:0] r_ir;
    logic [WAIT_W-1:0] r_wait;
    logic              r_wr;
    logic              r_ir_valid;
    logic              r_data_done;
    logic              r_err;
    logic              w_ack;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_pc_upd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_state_nxt = HALTED;
                end else if (start_fetch) begin
                    w_state_nxt = IFETCH;
                end else if (mem_req) begin
                    w_state_nxt = DACCESS;
                end
            end
            IFETCH, DACCESS: begin
                if (mem.mem_ready) begin
                    w_ack       = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wait == C_WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = HALTED;
                end
            end
            HALTED: w_state_nxt = HALTED;
            default: w_state_nxt = IDLE;
        endcase
    end

    // PC_REL adds to a PC that already points past the branch instruction.
    always_comb begin
        w_pc_upd = r_pc;
        case (pc_sel)
            PC_INC:  w_pc_upd = r_pc + ADDR_W'(1);
            PC_REL:  w_pc_upd = r_pc + offset[ADDR_W-1:0];
            PC_ABS:  w_pc_upd = abs_addr[ADDR_W-1:0];
            default: w_pc_upd = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_da        <= '0;
            r_ir        <= '0;
            r_wait      <= '0;
            r_wr        <= 1'b0;
            r_ir_valid  <= 1'b0;
            r_data_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ir_valid  <= 1'b0;
            r_data_done <= 1'b0;
            if (r_state == IDLE) begin
                r_wait <= '0;
                if (pc_load) begin
                    r_pc <= w_pc_upd;
                end
                if (w_state_nxt == DACCESS) begin
                    r_wr <= mem_wr;
                end
            end
            // The data address must stay stable while a data access is open.
            if (load_addr && (r_state != DACCESS)) begin
                r_da <= abs_addr[ADDR_W-1:0];
            end
            if ((r_state == IFETCH) || (r_state == DACCESS)) begin
                if (!w_ack && !w_timeout) begin
                    r_wait <= r_wait + WAIT_W'(1);
                end
            end
            if (w_ack && (r_state == IFETCH)) begin
                r_ir       <= mem.read_data;
                r_pc       <= r_pc + ADDR_W'(1);
                r_ir_valid <= 1'b1;
            end
            if (w_ack && (r_state == DACCESS)) begin
                r_data_done <= 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem.mem_cmd  = (r_state == IFETCH)  ? MREAD :
                          (r_state == DACCESS) ? (r_wr ? MWRITE : MREAD) : MNONE;
    assign mem.mem_addr = (r_state == IFETCH)  ? r_pc :
                          (r_state == DACCESS) ? r_da : '0;

    assign ir        = r_ir;
    assign pc        = r_pc;
    assign ir_valid  = r_ir_valid;
    assign data_done = r_data_done;
    assign busy      = (r_state == IFETCH) || (r_state == DACCESS);
    assign halted    = (r_state == HALTED);
    assign err       = r_err;

    generate
        if (DATA_W > ADDR_W) begin : g_upper_bits
            logic w_unused_upper;
            assign w_unused_upper = ^{offset[DATA_W-1:ADDR_W], abs_addr[DATA_W-1:ADDR_W]};
        end
    endgenerate

endmodule
`default_nettype wire
